// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Shares the single register-file write port among three producers of
// write-back results: requester 0 (ALU), requester 1 (load unit) and
// requester 2 (CSR unit). A round-robin pointer names the requester with the
// highest priority this cycle. At most one request is accepted per cycle. The
// accepted write is presented one cycle later on the registered write port.
//
// Parameters
//   XLEN       width of write data
//   AW         register-file address width
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        asynchronous, active-low reset
//   HOLD       when high, no request is accepted this cycle
//   REQ_VALID  per-requester write request, one bit per requester
//   REQ_ADDR   per-requester destination register, slice i = [i*AW +: AW]
//   REQ_DATA   per-requester write data, slice i = [i*XLEN +: XLEN]
//   REQ_READY  combinational one-hot grant, request i accepted this cycle
//   WE         registered register-file write enable, one-cycle pulse
//   WADDR      registered register-file write address
//   WDATA      registered register-file write data
//   GRANT_ID   registered index of the requester that owns the WE cycle
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HOLD,
  input  logic [2:0]        REQ_VALID,
  input  logic [3*AW-1:0]   REQ_ADDR,
  input  logic [3*XLEN-1:0] REQ_DATA,
  output logic [2:0]        REQ_READY,
  output logic              WE,
  output logic [AW-1:0]     WADDR,
  output logic [XLEN-1:0]   WDATA,
  output logic [1:0]        GRANT_ID
);

  // Round-robin pointer: index of the highest-priority requester.
  // Only the values 0, 1 and 2 are ever stored.
  logic [1:0]      ptr;

  // Result of the search in the current cycle.
  logic            grant_any;
  logic [1:0]      grant_idx;
  logic [1:0]      cand;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  // Modulo-3 increment. The value 2 wraps to 0 so the pointer never
  // reaches 3.
  function automatic logic [1:0] wrap_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration: search in the order ptr, ptr+1, ptr+2 (mod 3). The first
  // valid requester found wins. Reset and HOLD suppress every grant, so
  // REQ_READY stays low while RST is low whatever REQ_VALID does.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default value before any branch assigns it.
    // Without this, a path that skips an assignment infers a latch.
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = ptr;
    if (RST && !HOLD) begin
      for (int k = 0; k < 3; k++) begin
        if (!grant_any && REQ_VALID[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
        cand = wrap_inc(cand);
      end
    end
  end

  // A grant only exists for a valid request, so REQ_READY[i] can never be
  // high while REQ_VALID[i] is low.
  assign REQ_READY = grant_any ? (3'b001 << grant_idx) : 3'b000;

  // Address and data of the winning requester.
  assign sel_addr = REQ_ADDR[grant_idx*AW +: AW];
  assign sel_data = REQ_DATA[grant_idx*XLEN +: XLEN];

  // ---------------------------------------------------------------------------
  // Registered write port and pointer update.
  //
  // A grant to a request for x0 still consumes the request. It also updates
  // WADDR, WDATA and GRANT_ID, but it never raises WE. A cycle without a
  // grant clears WE and keeps the other write-port registers as they were.
  //
  // Asserting reset clears WE at once. Any write that was registered but not
  // yet performed is therefore dropped, and no write follows the release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: every register of this small block is cleared by the asynchronous
    // reset, because downstream logic samples WE as soon as reset releases.
    if (!RST) begin
      WE       <= 1'b0;
      WADDR    <= '0;
      WDATA    <= '0;
      GRANT_ID <= 2'd0;
      ptr      <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then sample values from before this edge, whatever the statement
      // order.
      WE <= grant_any && (sel_addr != '0);
      if (grant_any) begin
        WADDR    <= sel_addr;
        WDATA    <= sel_data;
        GRANT_ID <= grant_idx;
        ptr      <= wrap_inc(grant_idx);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed test of wb_arbiter. A table of per-cycle vectors runs in order
// from reset. Each vector gives the inputs, the REQ_READY expected in the
// same cycle, and the write-port registers expected after the following
// rising edge. Hand-written sequences then cover reset behaviour. The bench
// tracks the pointer by the grant order it expects.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [XLEN-1:0] DA = 32'hAAAA_0001;
  localparam logic [XLEN-1:0] DB = 32'hBBBB_0002;
  localparam logic [XLEN-1:0] DC = 32'hCCCC_0003;
  localparam logic [XLEN-1:0] DX = 32'hDEAD_BEEF;

  logic              CLK;
  logic              RST;
  logic              HOLD;
  logic [2:0]        REQ_VALID;
  logic [3*AW-1:0]   REQ_ADDR;
  logic [3*XLEN-1:0] REQ_DATA;
  logic [2:0]        REQ_READY;
  logic              WE;
  logic [AW-1:0]     WADDR;
  logic [XLEN-1:0]   WDATA;
  logic [1:0]        GRANT_ID;

  wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .HOLD      (HOLD),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .WE        (WE),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .GRANT_ID  (GRANT_ID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic            hold;
    logic [2:0]      valid;
    logic [AW-1:0]   a0;
    logic [XLEN-1:0] d0;
    logic [2:0]      ready;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      gid;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Requesters 1 and 2 always target x2 / x3 with data B / C.
  // Requester 0 gets its address and data from the vector.
  task automatic drive(input logic hold, input logic [2:0] valid,
                       input logic [AW-1:0] a0, input logic [XLEN-1:0] d0);
    HOLD      = hold;
    REQ_VALID = valid;
    REQ_ADDR  = {5'd3, 5'd2, a0};
    REQ_DATA  = {DC, DB, d0};
  endtask

  function automatic vec_t mk(input logic hold, input logic [2:0] valid,
                              input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                              input logic [2:0] ready, input logic we,
                              input logic [AW-1:0] waddr, input logic [XLEN-1:0] wdata,
                              input logic [1:0] gid);
    vec_t v;
    v.hold = hold; v.valid = valid; v.a0 = a0; v.d0 = d0;
    v.ready = ready; v.we = we; v.waddr = waddr; v.wdata = wdata; v.gid = gid;
    return v;
  endfunction

  task automatic check_regs(input string tag, input logic we, input logic [AW-1:0] waddr,
                            input logic [XLEN-1:0] wdata, input logic [1:0] gid);
    check({tag, ".we"},    64'(WE),       64'(we));
    check({tag, ".waddr"}, 64'(WADDR),    64'(waddr));
    check({tag, ".wdata"}, 64'(WDATA),    64'(wdata));
    check({tag, ".gid"},   64'(GRANT_ID), 64'(gid));
  endtask

  initial begin
    // Reset held with all requesters valid: nothing may be granted.
    RST = 1'b0;
    drive(1'b0, 3'b111, 5'd1, DA);
    #2;
    check("rst.ready", 64'(REQ_READY), 64'(3'b000));
    check_regs("rst", 1'b0, '0, '0, 2'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 3'b000, 5'd1, DA);
    RST = 1'b1;

    // Expected pointer after each vector is shown in the trailing comment.
    // rr over three requesters
    vecs.push_back(mk(0, 3'b111, 5'd1, DA, 3'b001, 1, 5'd1, DA, 2'd0)); // ptr 1
    vecs.push_back(mk(0, 3'b111, 5'd1, DA, 3'b010, 1, 5'd2, DB, 2'd1)); // ptr 2
    vecs.push_back(mk(0, 3'b111, 5'd1, DA, 3'b100, 1, 5'd3, DC, 2'd2)); // ptr 0
    // 0 and 2 alternate, 1 is never asked
    vecs.push_back(mk(0, 3'b101, 5'd1, DA, 3'b001, 1, 5'd1, DA, 2'd0)); // ptr 1
    vecs.push_back(mk(0, 3'b101, 5'd1, DA, 3'b100, 1, 5'd3, DC, 2'd2)); // ptr 0
    vecs.push_back(mk(0, 3'b101, 5'd1, DA, 3'b001, 1, 5'd1, DA, 2'd0)); // ptr 1
    vecs.push_back(mk(0, 3'b101, 5'd1, DA, 3'b100, 1, 5'd3, DC, 2'd2)); // ptr 0
    // HOLD blocks for four cycles, registers keep their values
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 3'b010, 5'd1, DA, 3'b000, 0, 5'd3, DC, 2'd2)); // ptr 0
    // released: same-cycle grant, write on the next cycle
    vecs.push_back(mk(0, 3'b010, 5'd1, DA, 3'b010, 1, 5'd2, DB, 2'd1)); // ptr 2
    // pointer wrap: grant to 2, then 0 wins among all three
    vecs.push_back(mk(0, 3'b100, 5'd1, DA, 3'b100, 1, 5'd3, DC, 2'd2)); // ptr 0
    vecs.push_back(mk(0, 3'b111, 5'd1, DA, 3'b001, 1, 5'd1, DA, 2'd0)); // ptr 1
    // write to x0: consumed, WE stays low, other registers update
    vecs.push_back(mk(0, 3'b001, 5'd0, DX, 3'b001, 0, 5'd0, DX, 2'd0)); // ptr 1
    // idle, then HOLD with all valid: nothing moves
    vecs.push_back(mk(0, 3'b000, 5'd1, DA, 3'b000, 0, 5'd0, DX, 2'd0)); // ptr 1
    vecs.push_back(mk(1, 3'b111, 5'd1, DA, 3'b000, 0, 5'd0, DX, 2'd0)); // ptr 1
    // pointer held at 1 through the x0 grant and the idle cycles
    vecs.push_back(mk(0, 3'b110, 5'd1, DA, 3'b010, 1, 5'd2, DB, 2'd1)); // ptr 2

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge CLK);
      drive(vecs[i].hold, vecs[i].valid, vecs[i].a0, vecs[i].d0);
      #1;
      check({tag, ".ready"}, 64'(REQ_READY), 64'(vecs[i].ready));
      @(posedge CLK);
      #1;
      check_regs(tag, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].gid);
    end

    // Reset mid-operation: requester 2 is granted and its write is pending.
    @(negedge CLK);
    drive(1'b0, 3'b100, 5'd1, DA);
    #1;
    check("mid.ready", 64'(REQ_READY), 64'(3'b100));
    @(posedge CLK);
    #1;
    check_regs("mid.pend", 1'b1, 5'd3, DC, 2'd2);
    drive(1'b0, 3'b111, 5'd1, DA);
    #1;
    RST = 1'b0;
    #1;
    check_regs("mid.rst", 1'b0, '0, '0, 2'd0);
    check("mid.rst.ready", 64'(REQ_READY), 64'(3'b000));
    @(posedge CLK);
    #1;
    check("mid.rst.hold.we", 64'(WE), 64'(1'b0));

    // Release with no request: the dropped write must not appear.
    @(negedge CLK);
    drive(1'b0, 3'b000, 5'd1, DA);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_regs("rel.idle", 1'b0, '0, '0, 2'd0);

    // The pointer restarts at 0, so requester 0 wins among all three.
    @(negedge CLK);
    drive(1'b0, 3'b111, 5'd1, DA);
    #1;
    check("rel.ready", 64'(REQ_READY), 64'(3'b001));
    @(posedge CLK);
    #1;
    check_regs("rel.wr", 1'b1, 5'd1, DA, 2'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of write data.
REQ-002 SHALL have parameter AW, default 5, register-file address width.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port HOLD  input  1  when high, blocks all grants this cycle.
REQ-006 SHALL have port REQ_VALID  input  3  per-requester write request (bit0 ALU, bit1 load unit, bit2 CSR unit).
REQ-007 SHALL have port REQ_ADDR  input  3*AW  per-requester destination register; slice i = bits [i*AW +: AW].
REQ-008 SHALL have port REQ_DATA  input  3*XLEN  per-requester write data; slice i = bits [i*XLEN +: XLEN].
REQ-009 SHALL have port REQ_READY  output  3  one-hot grant; high = request i accepted this cycle.
REQ-010 SHALL have port WE  output  1  registered register-file write enable.
REQ-011 SHALL have port WADDR  output  AW  registered register-file write address.
REQ-012 SHALL have port WDATA  output  XLEN  registered register-file write data.
REQ-013 SHALL have port GRANT_ID  output  2  registered index of requester owning current WE cycle (0..2).

Function
REQ-014 SHALL share one register-file write port among 3 requesters; at most one grant per cycle.
REQ-015 SHALL drive REQ_READY combinationally from REQ_VALID, HOLD and the priority pointer; REQ_READY[i] SHALL never be high while REQ_VALID[i] is low.
REQ-016 SHALL produce REQ_READY = 3'b000 whenever HOLD=1 or REQ_VALID=3'b000.
REQ-017 SHALL arbitrate round-robin: a 2-bit pointer PTR names the highest-priority requester; search order PTR, PTR+1, PTR+2 (mod 3).
REQ-018 SHALL, on a grant to requester i, update PTR to (i+1) mod 3 at the next edge; without a grant PTR SHALL hold.
REQ-019 SHALL never let PTR take value 3; wrap 2 -> 0.
REQ-020 SHALL, on a grant to i in cycle t, present WADDR=REQ_ADDR slice i, WDATA=REQ_DATA slice i, GRANT_ID=i, WE=1 in cycle t+1 (latency 1, single-cycle pulse).
REQ-021 SHALL, on a grant whose REQ_ADDR slice is 0 (x0), consume the request (REQ_READY high) but keep WE=0 in t+1; WADDR/WDATA/GRANT_ID still update.
REQ-022 SHALL, in any cycle without a grant, drive WE=0 next cycle and hold WADDR, WDATA, GRANT_ID unchanged.
REQ-023 SHALL support back-to-back grants: WE high on consecutive cycles when grants occur on consecutive cycles.
REQ-024 SHALL require requesters to keep REQ_VALID, REQ_ADDR, REQ_DATA stable until REQ_READY; arbiter behaviour for unstable requests is not defined.
REQ-025 SHALL guarantee starvation freedom: a continuously valid requester is granted within 3 non-HOLD cycles.
REQ-026 SHALL not resolve same-address collisions; two requests to one address are written in grant order.

Reset
REQ-027 SHALL, while RST=0, asynchronously force WE=0, WADDR=0, WDATA=0, GRANT_ID=0, PTR=0.
REQ-028 SHALL keep REQ_READY=3'b000 while RST=0 regardless of REQ_VALID.
REQ-029 SHALL, on reset asserted mid-operation, drop any registered pending write (WE=0 immediately, no write after release).
REQ-030 SHALL resume arbitration on the first rising CLK edge after RST deasserts with PTR=0.

Verification
REQ-031 SHALL test: after reset, REQ_VALID=3'b111, addrs 1/2/3, data A/B/C, HOLD=0 for 3 cycles -> REQ_READY 001, 010, 100; WE=1 with WADDR 1,2,3 / WDATA A,B,C in following 3 cycles, GRANT_ID 0,1,2.
REQ-032 SHALL test: REQ_VALID=3'b101 held, PTR=0 -> grants 0,2,0,2 alternating; requester 1 never granted.
REQ-033 SHALL test: HOLD=1 with REQ_VALID=3'b010 for 4 cycles -> REQ_READY=0, WE=0, PTR unchanged; HOLD=0 -> REQ_READY=010 same cycle, WE=1 next cycle.
REQ-034 SHALL test: single request, requester 0, REQ_ADDR=0, data 0xDEADBEEF -> REQ_READY[0]=1, next cycle WE=0, WDATA=0xDEADBEEF, GRANT_ID=0.
REQ-035 SHALL test: grant to requester 2 in cycle t, RST=0 asserted between t and t+1 edge -> WE=0 immediately, all outputs 0, PTR=0 after release.
REQ-036 SHALL test: PTR wrap; grant to 2 then REQ_VALID=3'b111 -> next grant to 0.
